// File: rtl/branch_target_unit_if.sv
// Request/response bundle for branch_target_unit.
// Parameters: DATA_W, IMM_W, IDX_W, DEPTH (must match the unit's parameters).
// Request side : in_valid, in_ready, in_mode, in_taken, in_pcnext, in_imm, in_index, in_reg
// Response side: out_valid, out_ready, out_target, out_redirect, count
// Optional     : out_misaligned when BTU_ALIGN_CHECK_EN is defined.
// master = decode/fetch side driving requests and consuming targets; slave = the unit.
interface branch_target_unit_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned IDX_W  = 26,
    parameter int unsigned DEPTH  = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_mode;
    logic              in_taken;
    logic [DATA_W-1:0] in_pcnext;
    logic [IMM_W-1:0]  in_imm;
    logic [IDX_W-1:0]  in_index;
    logic [DATA_W-1:0] in_reg;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_target;
    logic              out_redirect;
    logic [CNT_W-1:0]  count;
`ifdef BTU_ALIGN_CHECK_EN
    logic              out_misaligned;

    modport master (
        output in_valid, in_mode, in_taken, in_pcnext, in_imm, in_index, in_reg, out_ready,
        input  in_ready, out_valid, out_target, out_redirect, count, out_misaligned
    );
    modport slave (
        input  in_valid, in_mode, in_taken, in_pcnext, in_imm, in_index, in_reg, out_ready,
        output in_ready, out_valid, out_target, out_redirect, count, out_misaligned
    );
`else
    modport master (
        output in_valid, in_mode, in_taken, in_pcnext, in_imm, in_index, in_reg, out_ready,
        input  in_ready, out_valid, out_target, out_redirect, count
    );
    modport slave (
        input  in_valid, in_mode, in_taken, in_pcnext, in_imm, in_index, in_reg, out_ready,
        output in_ready, out_valid, out_target, out_redirect, count
    );
`endif
endinterface

// File: rtl/branch_target_unit.sv
// branch_target_unit: computes next-PC targets (PC-relative branch, region jump,
// register jump, sequential) and queues {target, redirect} in a DEPTH-entry FIFO.
// Ports: clk, rst_n (async active-low), bus (branch_target_unit_if.slave).
// Optional feature macro: BTU_ALIGN_CHECK_EN adds a per-entry out_misaligned flag.
// Handshake outputs depend on registered occupancy only; full blocks pushes even
// when a pop happens in the same cycle.
module branch_target_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned IDX_W  = 26,
    parameter int unsigned SHIFT  = 2,
    parameter int unsigned DEPTH  = 2
) (
    input logic                clk,
    input logic                rst_n,
    branch_target_unit_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned EXT_W = DATA_W - IMM_W;
    localparam int unsigned HI_W  = DATA_W - IDX_W - SHIFT;

    typedef enum logic [1:0] {
        MODE_BRANCH = 2'b00,
        MODE_JUMP   = 2'b01,
        MODE_REG    = 2'b10,
        MODE_NEXT   = 2'b11
    } mode_e;

    logic [DATA_W-1:0] tgt_mem_q [DEPTH];
    logic [DEPTH-1:0]  redir_mem_q;
`ifdef BTU_ALIGN_CHECK_EN
    logic [DEPTH-1:0]  mis_mem_q;
`endif
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DATA_W-1:0] imm_off_c;
    logic [DATA_W-1:0] tgt_c;
    logic              redir_c;
    logic              push_c;
    logic              pop_c;

    // Target computation from the current request.
    always_comb begin
        imm_off_c = {{EXT_W{bus.in_imm[IMM_W-1]}}, bus.in_imm} << SHIFT;
        tgt_c     = bus.in_pcnext;
        redir_c   = 1'b0;
        case (mode_e'(bus.in_mode))
            MODE_BRANCH: begin
                if (bus.in_taken) begin
                    tgt_c   = bus.in_pcnext + imm_off_c;
                    redir_c = 1'b1;
                end
            end
            MODE_JUMP: begin
                tgt_c   = {bus.in_pcnext[DATA_W-1 -: HI_W], bus.in_index, {SHIFT{1'b0}}};
                redir_c = 1'b1;
            end
            MODE_REG: begin
                tgt_c   = bus.in_reg;
                redir_c = 1'b1;
            end
            default: begin
                tgt_c   = bus.in_pcnext;
                redir_c = 1'b0;
            end
        endcase
    end

    // Handshakes use registered occupancy only.
    assign push_c = bus.in_valid && (count_q != CNT_W'(DEPTH));
    assign pop_c  = bus.out_ready && (count_q != '0);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
        count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // State and storage; reset flushes every entry so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            redir_mem_q <= '0;
`ifdef BTU_ALIGN_CHECK_EN
            mis_mem_q   <= '0;
`endif
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tgt_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_c) begin
                tgt_mem_q[wr_ptr_q]   <= tgt_c;
                redir_mem_q[wr_ptr_q] <= redir_c;
`ifdef BTU_ALIGN_CHECK_EN
                mis_mem_q[wr_ptr_q]   <= (tgt_c[SHIFT-1:0] != '0);
`endif
            end
        end
    end

    assign bus.in_ready     = (count_q != CNT_W'(DEPTH));
    assign bus.out_valid    = (count_q != '0);
    assign bus.out_target   = tgt_mem_q[rd_ptr_q];
    assign bus.out_redirect = redir_mem_q[rd_ptr_q];
    assign bus.count        = count_q;
`ifdef BTU_ALIGN_CHECK_EN
    assign bus.out_misaligned = mis_mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_branch_target_unit.sv
// Directed bench for branch_target_unit with a queue-based reference model.
// Inputs change 1 time unit after a rising edge; outputs are checked on falling edges.
module tb_branch_target_unit;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned IDX_W  = 26;
    localparam int unsigned SHIFT  = 2;
    localparam int unsigned DEPTH  = 2;

    typedef struct packed {
        logic [31:0] t;
        logic        r;
        logic        m;
    } ent_t;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    ent_t mq[$];
    logic [31:0] got[$];

    branch_target_unit_if #(.DATA_W(DATA_W), .IMM_W(IMM_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) bus ();

    branch_target_unit #(
        .DATA_W(DATA_W), .IMM_W(IMM_W), .IDX_W(IDX_W), .SHIFT(SHIFT), .DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference target computation written from the mode rules with plain arithmetic.
    function automatic ent_t model_calc(input logic [1:0] mode, input logic taken,
                                        input logic [31:0] pc, input logic [15:0] imm,
                                        input logic [25:0] idx, input logic [31:0] rg);
        ent_t   e;
        longint v;
        case (mode)
            2'd0: begin
                if (taken) begin
                    v   = longint'(pc) + longint'($signed(imm)) * 4;
                    e.r = 1'b1;
                end else begin
                    v   = longint'(pc);
                    e.r = 1'b0;
                end
            end
            2'd1: begin
                v   = (longint'(pc) / (64'd1 << 28)) * (64'd1 << 28) + longint'(idx) * 4;
                e.r = 1'b1;
            end
            2'd2: begin
                v   = longint'(rg);
                e.r = 1'b1;
            end
            default: begin
                v   = longint'(pc);
                e.r = 1'b0;
            end
        endcase
        e.t = v[31:0];
        e.m = (e.t % 4) != 0;
        return e;
    endfunction

    // Model update on each edge: pushes only when not full before the edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
        end else begin
            bit   do_push;
            bit   do_pop;
            do_push = bus.in_valid && (mq.size() < DEPTH);
            do_pop  = bus.out_ready && (mq.size() != 0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(model_calc(bus.in_mode, bus.in_taken, bus.in_pcnext,
                                                 bus.in_imm, bus.in_index, bus.in_reg));
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < DEPTH));
            chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
            chk("count", 64'(bus.count), 64'(mq.size()));
            if (mq.size() != 0) begin
                chk("head_target", 64'(bus.out_target), 64'(mq[0].t));
                chk("head_redirect", 64'(bus.out_redirect), 64'(mq[0].r));
`ifdef BTU_ALIGN_CHECK_EN
                chk("head_misaligned", 64'(bus.out_misaligned), 64'(mq[0].m));
`endif
            end
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_target);
        end
    end

    task automatic drive(input logic [1:0] mode, input logic taken, input logic [31:0] pc,
                         input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rg);
        bus.in_valid  = 1'b1;
        bus.in_mode   = mode;
        bus.in_taken  = taken;
        bus.in_pcnext = pc;
        bus.in_imm    = imm;
        bus.in_index  = idx;
        bus.in_reg    = rg;
    endtask

    // Holds the current request until accepted; returns 1 unit after the accepting edge.
    task automatic wait_accept(input string name);
        bit acc;
        acc = 1'b0;
        for (int c = 0; c < 20 && !acc; c++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL %s: request not accepted within 20 cycles", name);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input string name, input logic [1:0] mode, input logic taken,
                        input logic [31:0] pc, input logic [15:0] imm, input logic [25:0] idx,
                        input logic [31:0] rg);
        @(posedge clk);
        #1;
        drive(mode, taken, pc, imm, idx, rg);
        wait_accept(name);
    endtask

    // Single request through an idle unit with out_ready high; checks the head one cycle later.
    task automatic one_shot(input string name, input logic [1:0] mode, input logic taken,
                            input logic [31:0] pc, input logic [15:0] imm, input logic [25:0] idx,
                            input logic [31:0] rg, input logic [31:0] exp_t, input logic exp_r);
        send(name, mode, taken, pc, imm, idx, rg);
        @(negedge clk);
        chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({name, "_target"}, 64'(bus.out_target), 64'(exp_t));
        chk({name, "_redirect"}, 64'(bus.out_redirect), 64'(exp_r));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 2'd0;
        bus.in_taken  = 1'b0;
        bus.in_pcnext = '0;
        bus.in_imm    = '0;
        bus.in_index  = '0;
        bus.in_reg    = '0;
        bus.out_ready = 1'b0;

        #7;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_target", 64'(bus.out_target), 64'd0);
        chk("rst_redirect", 64'(bus.out_redirect), 64'd0);
        #5 rst_n = 1'b1;

        bus.out_ready = 1'b1;
        one_shot("br_taken", 2'd0, 1'b1, 32'h0000_0004, 16'h000F, '0, '0, 32'h0000_0040, 1'b1);
        one_shot("br_neg1", 2'd0, 1'b1, 32'h0000_0004, 16'hFFFF, '0, '0, 32'h0000_0000, 1'b1);
        one_shot("br_minneg", 2'd0, 1'b1, 32'h0000_0010, 16'h8000, '0, '0, 32'hFFFE_0010, 1'b1);
        one_shot("br_wrap", 2'd0, 1'b1, 32'hFFFF_FFFC, 16'h0002, '0, '0, 32'h0000_0004, 1'b1);
        one_shot("br_not", 2'd0, 1'b0, 32'h0000_0004, 16'h1234, '0, '0, 32'h0000_0004, 1'b0);
        one_shot("jump", 2'd1, 1'b0, 32'hBFC0_0004, '0, 26'h000_0010, '0, 32'hB000_0040, 1'b1);
        one_shot("jump_tk", 2'd1, 1'b1, 32'h7000_0000, '0, 26'h3FF_FFFF, '0, 32'h7FFF_FFFC, 1'b1);
        one_shot("reg", 2'd2, 1'b0, 32'h0000_0100, '0, '0, 32'h1234_5678, 32'h1234_5678, 1'b1);
        one_shot("next", 2'd3, 1'b1, 32'h0000_0100, 16'h0F0F, '0, '0, 32'h0000_0100, 1'b0);

`ifdef BTU_ALIGN_CHECK_EN
        send("reg_mis", 2'd2, 1'b0, '0, '0, '0, 32'h0000_0006);
        @(negedge clk);
        chk("reg_misaligned", 64'(bus.out_misaligned), 64'd1);
        chk("reg_mis_target", 64'(bus.out_target), 64'h6);
        send("br_aligned", 2'd0, 1'b1, 32'h0000_0004, 16'h0003, '0, '0);
        @(negedge clk);
        chk("br_misaligned", 64'(bus.out_misaligned), 64'd0);
`endif

        // Backpressure: third request must wait for the first pop and arrive in order.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        got.delete();
        send("bp_a", 2'd2, 1'b0, '0, '0, '0, 32'hAAAA_0000);
        send("bp_b", 2'd2, 1'b0, '0, '0, '0, 32'hBBBB_0000);
        @(negedge clk);
        chk("bp_full_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_full_count", 64'(bus.count), 64'd2);
        chk("bp_full_head", 64'(bus.out_target), 64'hAAAA_0000);
        @(posedge clk);
        #1;
        drive(2'd2, 1'b0, '0, '0, '0, 32'hCCCC_0000);
        repeat (2) begin
            @(negedge clk);
            chk("bp_held_count", 64'(bus.count), 64'd2);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_accept("bp_c");
        repeat (3) @(negedge clk);
        chk("bp_pops", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("bp_order0", 64'(got[0]), 64'hAAAA_0000);
            chk("bp_order1", 64'(got[1]), 64'hBBBB_0000);
            chk("bp_order2", 64'(got[2]), 64'hCCCC_0000);
        end

        // Simultaneous push and pop with one entry held.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send("sp_d", 2'd3, 1'b0, 32'h0000_D000, '0, '0, '0);
        drive(2'd3, 1'b0, 32'h0000_E000, '0, '0, '0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("sp_count", 64'(bus.count), 64'd1);
        chk("sp_head", 64'(bus.out_target), 64'h0000_E000);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset with the buffer full.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send("rs_f", 2'd2, 1'b0, '0, '0, '0, 32'h1111_1111);
        send("rs_g", 2'd2, 1'b0, '0, '0, '0, 32'h2222_2222);
        @(negedge clk);
        chk("rs_pre_count", 64'(bus.count), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rs_count", 64'(bus.count), 64'd0);
        chk("rs_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rs_target", 64'(bus.out_target), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        one_shot("post_rst", 2'd1, 1'b0, 32'h4000_0000, '0, 26'h000_0001, '0, 32'h4000_0004, 1'b1);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_target_unit.md
Name: branch_target_unit

Overview:
Parametrised, registered successor to the combinational branch address calculation. Computes next-PC targets for PC-relative branches, region jumps and register jumps, selected by a mode input. Results are queued in a DEPTH-entry output buffer with valid/ready handshakes on both sides. Sits between decode and fetch-redirect logic; the buffer decouples decode from fetch stalls.

Parameters:
DATA_W, 32, address/PC width in bits
IMM_W, 16, branch immediate width (sign-extended to DATA_W)
IDX_W, 26, jump instruction-index width
SHIFT, 2, left shift applied to immediate and index (word alignment)
DEPTH, 2, output buffer entries (power of two, >= 2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept request
in_mode  input  2  00 BRANCH, 01 JUMP, 10 REG, 11 NEXT
in_taken  input  1  branch condition result (BRANCH mode only)
in_pcnext  input  DATA_W  PC+4 of the branch instruction
in_imm  input  IMM_W  branch immediate
in_index  input  IDX_W  jump instruction index
in_reg  input  DATA_W  register operand for REG mode
out_valid  output  1  target available at buffer head
out_ready  input  1  consumer accepts head entry
out_target  output  DATA_W  computed next PC
out_redirect  output  1  1 if out_target differs from sequential flow (taken/jump)
count  output  clog2(DEPTH)+1  buffer occupancy

Behaviour:
- Reset (asynchronous, rst_n low): buffer flushed, read/write pointers 0, count 0, out_valid 0, out_target 0, out_redirect 0, in_ready 1. Applies mid-transfer; in-flight entries are discarded.
- Target computation (combinational on inputs, registered on push), all arithmetic modulo 2^DATA_W:
  - BRANCH: taken=1 -> in_pcnext + (sext(in_imm) << SHIFT), redirect=1; taken=0 -> in_pcnext, redirect=0.
  - JUMP: {in_pcnext[DATA_W-1 : IDX_W+SHIFT], in_index, SHIFT zero bits}, redirect=1; in_taken ignored.
  - REG: in_reg unmodified, redirect=1.
  - NEXT: in_pcnext, redirect=0.
- Push: in_valid && in_ready at rising edge writes {target, redirect} at write pointer.
- Pop: out_valid && out_ready at rising edge advances read pointer.
- in_ready = (count != DEPTH); out_valid = (count != 0); both derived from registered state only, no combinational input-to-output path.
- Latency: request accepted at edge N appears at head (if buffer was empty) with out_valid=1 after edge N; minimum 1 cycle.
- Simultaneous push and pop (not full, not empty): both occur, count unchanged, order preserved (FIFO).
- Full: in_ready=0; in_valid ignored, even if a pop occurs the same cycle (no pass-through).
- Empty: out_valid=0; out_ready ignored; out_target holds last popped value (not checked).
- Stall: while out_valid && !out_ready, out_target/out_redirect stable.
- Pointers wrap modulo DEPTH.

Optional Feature:
Macro BTU_ALIGN_CHECK_EN. When defined: extra output out_misaligned (1 bit), stored per entry, =1 when target[SHIFT-1:0] != 0 (only REG mode can produce it); reset value 0; entry still delivered unmodified. When undefined: port and per-entry storage absent; no alignment check.

Test Plan:
- BRANCH taken, imm=0x000F, pcnext=0x00000004, out_ready=1 -> one cycle later out_valid=1, out_target=0x00000040, out_redirect=1.
- BRANCH taken, imm=0xFFFF, pcnext=0x00000004 -> 0x00000000; imm=0x8000, pcnext=0x00000010 -> 0xFFFE0010 (sign extension, wrap); taken=0 -> 0x00000004, redirect=0.
- JUMP pcnext=0xBFC00004, index=0x0000010 -> 0xB0000040; REG in_reg=0x12345678 -> 0x12345678, redirect=1; NEXT pcnext=0x100 -> 0x100, redirect=0.
- Backpressure: out_ready=0, push 3 requests with DEPTH=2 -> in_ready=0 after 2nd push, count=2, 3rd held; raise out_ready -> outputs in push order, 3rd accepted after first pop, no loss/duplication.
- Simultaneous push/pop at count=1 -> count stays 1, next head correct; rst_n low mid-stream with count=2 -> immediately out_valid=0, count=0, in_ready=1, out_target=0.
- With BTU_ALIGN_CHECK_EN: REG in_reg=0x00000006 -> out_misaligned=1; BRANCH result -> out_misaligned=0.
